// File: rtl/agc_loop_param.sv
// agc_loop_param: single-clock AGC with block-averaged envelope, attack/decay gain update, lock flag and output scaling
module agc_loop_param #(
  parameter int DW = 12,
  parameter int DECIM = 8,
  parameter int GW = 16,
  parameter int FRAC = 12,
  parameter int GAIN_INIT = 4096,
  parameter int GAIN_MIN = 1,
  parameter int ATTACK_SH = 2,
  parameter int DECAY_SH = 4,
  parameter int LOCK_TOL = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [DW-1:0] sample_i,
  input  logic [DW-1:0] sample_q,
  input  logic [DW-1:0] threshold,
  input  logic freeze,
  input  logic gain_load,
  input  logic [GW-1:0] gain_load_val,
  output logic out_valid,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_q,
  output logic [GW-1:0] gain_out,
  output logic gain_valid,
  output logic locked
);
  localparam int LD = $clog2(DECIM);
  localparam int AW = DW + 1 + LD;
  localparam int LKW = $clog2(LOCK_CNT + 1);
  localparam logic [LKW-1:0] LK_FULL = LKW'(LOCK_CNT);
  localparam logic signed [DW+1:0] TOL = (DW+2)'(LOCK_TOL);
  localparam logic signed [GW+1:0] G_MIN = (GW+2)'(GAIN_MIN);
  localparam logic signed [GW+1:0] G_MAX = {2'b00, {GW{1'b1}}};
  localparam logic signed [DW+GW:0] S_MAX = (DW+GW+1)'(2**(DW-1) - 1);
  localparam logic signed [DW+GW:0] S_MIN = (DW+GW+1)'(-(2**(DW-1)));
  typedef enum logic {ACCUM, UPDATE} state_t;
  function automatic logic [DW:0] mag(input logic [DW-1:0] x);
    logic signed [DW:0] e;
    e = $signed({x[DW-1], x});
    return e[DW] ? $unsigned(-e) : $unsigned(e);
  endfunction
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x, input logic [GW-1:0] g);
    logic signed [DW+GW:0] xs, gs, p;
    xs = (DW+GW+1)'($signed(x));
    gs = (DW+GW+1)'($signed({1'b0, g}));
    p = (xs * gs) >>> FRAC;
    return p > S_MAX ? {1'b0, {(DW-1){1'b1}}} : p < S_MIN ? {1'b1, {(DW-1){1'b0}}} : p[DW-1:0];
  endfunction
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, tot;
  logic [LD-1:0] cnt_q, cnt_d;
  logic [DW:0] avg_q, avg_d, mi, mq, env;
  logic [GW-1:0] gain_q, gain_d, gnew, load_val;
  logic [LKW-1:0] lock_cnt_q, lock_cnt_d, lock_nxt;
  logic locked_q, locked_d, gain_valid_q, gain_valid_d, out_valid_q, out_valid_d;
  logic [DW-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic signed [DW+1:0] err, mag_err;
  logic signed [GW+1:0] step, gsum;
  logic wrap, upd;
  always_comb begin
    mi = mag(sample_i);
    mq = mag(sample_q);
    env = (mi > mq ? mi : mq) + ((mi > mq ? mq : mi) >> 1);
    tot = acc_q + AW'(env);
    wrap = in_valid && cnt_q == LD'(DECIM - 1);
    err = $signed({2'b00, threshold}) - $signed({1'b0, avg_q});
    mag_err = err[DW+1] ? -err : err;
    step = err[DW+1] ? (GW+2)'(err >>> ATTACK_SH) : (GW+2)'(err >>> DECAY_SH);
    gsum = $signed({2'b00, gain_q}) + step;
    gnew = gsum < G_MIN ? G_MIN[GW-1:0] : gsum > G_MAX ? G_MAX[GW-1:0] : gsum[GW-1:0];
    load_val = gain_load_val < GW'(GAIN_MIN) ? GW'(GAIN_MIN) : gain_load_val;
    upd = state_q == UPDATE && !freeze;
    lock_nxt = !upd ? lock_cnt_q : mag_err > TOL ? '0 : lock_cnt_q == LK_FULL ? lock_cnt_q : lock_cnt_q + LKW'(1);
    state_d = gain_load || !wrap ? ACCUM : UPDATE;
    acc_d = gain_load || wrap ? '0 : in_valid ? tot : acc_q;
    cnt_d = gain_load ? '0 : in_valid ? cnt_q + LD'(1) : cnt_q;
    avg_d = wrap ? tot[AW-1:LD] : avg_q;
    gain_d = gain_load ? load_val : upd ? gnew : gain_q;
    lock_cnt_d = gain_load ? '0 : lock_nxt;
    locked_d = lock_cnt_d == LK_FULL;
    gain_valid_d = !gain_load && state_q == UPDATE;
    out_valid_d = in_valid;
    out_i_d = in_valid ? scale(sample_i, gain_q) : out_i_q;
    out_q_d = in_valid ? scale(sample_q, gain_q) : out_q_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      gain_q <= GW'(GAIN_INIT);
      lock_cnt_q <= '0;
      locked_q <= 1'b0;
      gain_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q <= '0;
      out_q_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      gain_q <= gain_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q <= locked_d;
      gain_valid_q <= gain_valid_d;
      out_valid_q <= out_valid_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_i = out_i_q;
  assign out_q = out_q_q;
  assign gain_out = gain_q;
  assign gain_valid = gain_valid_q;
  assign locked = locked_q;
endmodule

// File: doc/agc_loop_param.md
# agc_loop_param

Parametrised single-clock automatic gain control loop, the next-generation replacement for the fixed 12-bit, dual-clock AGC chain. It estimates the I/Q envelope, averages it over a programmable block of samples using an internal decimation counter instead of a second clock, and updates a saturating gain register with separate attack and decay step sizes. It also applies the gain to the I/Q stream, reports loop lock, and supports freeze and direct gain load. It sits between the ADC front end and the demodulator.

## Interface

- DW, 12: I/Q sample width, signed two's complement.
- DECIM, 8: samples per averaging block; power of two, ≥ 2.
- GW, 16: gain word width, unsigned.
- FRAC, 12: gain fractional bits (unity = 2^FRAC).
- GAIN_INIT, 4096: gain after reset.
- GAIN_MIN, 1: lower gain clamp.
- ATTACK_SH, 2: right-shift applied to a negative error (signal too loud).
- DECAY_SH, 4: right-shift applied to a positive error.
- LOCK_TOL, 16: |error| tolerance for lock.
- LOCK_CNT, 4: consecutive in-tolerance blocks required to assert lock.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe.
- sample_i, sample_q  in  DW  signed input samples.
- threshold  in  DW  unsigned target envelope.
- freeze  in  1  hold gain while high.
- gain_load  in  1  one-cycle load strobe.
- gain_load_val  in  GW  value to load.
- out_valid  out  1  scaled sample strobe.
- out_i, out_q  out  DW  scaled, saturated samples.
- gain_out  out  GW  current gain.
- gain_valid  out  1  one-cycle pulse per gain update.
- locked  out  1  loop lock flag.

## Operation

- Envelope, combinational on the accepted sample: env = max(|I|,|Q|) + (min(|I|,|Q|) >> 1). Width is DW+1 unsigned; |−2^(DW−1)| = 2^(DW−1) with no wrap.
- Accumulator, DW+1+log2(DECIM) bits, adds env on each in_valid. A block counter, 0..DECIM−1, wraps on the DECIM-th sample.
- At that DECIM-th edge (E):
  - block sum is latched;
  - accumulator restarts at 0, so the next sample is not lost;
  - FSM goes ACCUM → UPDATE.
- UPDATE lasts one cycle, then returns to ACCUM. Samples accepted during UPDATE accumulate normally.
  - avg = sum >> log2(DECIM).
  - err = threshold − avg, signed DW+2 bits.
  - step = err >>> ATTACK_SH if err < 0, else err >>> DECAY_SH (arithmetic shift).
  - gain ← clamp(gain + step, GAIN_MIN, 2^GW−1), computed in GW+2 signed bits.
  - gain_valid pulses.
- Lock:
  - If |err| ≤ LOCK_TOL, the lock counter increments, saturating at LOCK_CNT; otherwise the counter and locked clear.
  - locked = (counter == LOCK_CNT), registered together with the gain update.
- Priority on each UPDATE/edge: rst > gain_load > freeze > update.
  - gain_load: gain ← gain_load_val clamped to ≥ GAIN_MIN. Also clears the accumulator, block counter and lock counter and deasserts locked. The FSM returns to ACCUM and no gain_valid pulse is issued for that block.
  - freeze: the block completes and gain_valid still pulses, but gain and lock state are held.
- Scaling: out_x = sat_DW((sample_x × gain) >>> FRAC), using the gain value present at the accept edge.

## Timing

- Reset values: gain_out = GAIN_INIT; out_i = out_q = 0; out_valid = 0; gain_valid = 0; locked = 0. Accumulator, counters and lock counter are 0; FSM is in ACCUM.
- Reset asserted mid-block discards the partial sum; the first block after release is DECIM fresh samples.
- out_valid/out_i/out_q follow in_valid by 1 cycle.
- The gain update is visible at edge E+1, where E is the edge accepting the DECIM-th sample. gain_valid is high for exactly the cycle after E+1. The new gain applies to samples accepted from edge E+2 on.
- in_valid may be high every cycle; there is no back-pressure.
- gain_load and freeze are sampled synchronously. Simultaneous gain_load and freeze: load wins.

## Test plan

- Reset: assert rst mid-block → gain_out = 4096, locked = 0, out_valid = 0 immediately, without waiting for a clock. After release, 8 new samples are needed before the first gain_valid.
- Decay: I = 400, Q = 0, threshold = 800, 8 consecutive samples → env 400, err +400, step 25 → gain_out 4121 one cycle after the 8th edge, gain_valid single pulse. out_i = 400 one cycle after each sample during the block.
- Attack: I = 300, Q = 200 (env 400), threshold = 200 → err −200, step −50 → gain 4046.
- Clamp: load 65530, then threshold 2047 with zero input → gain 65535. Load 10, then I = 2047, threshold 0 → gain 1 (GAIN_MIN).
- Lock: env = threshold + 10 for 4 blocks → locked rises with the 4th gain_valid. One block at +40 → locked falls at that update. Freeze during a +40 block → gain and locked unchanged, gain_valid still pulses.
- Saturation: gain 8192 with I = 2047, Q = −2048 → out_i = 2047, out_q = −2048. gain_load in the same cycle as freeze → gain equals the loaded value, and no gain_valid pulse for that block.
